// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared SM4 types, constants and word helpers
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  typedef logic [31:0]  sm4_word_t;
  typedef logic [127:0] sm4_block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } sm4_ctrl_state_e;

  function automatic sm4_word_t rotl(input sm4_word_t w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

endpackage

// File: rtl/transform_for_encdec.sv
// rtl/transform_for_encdec.sv - SM4 round T-transform: byte S-box layer then linear diffusion L
module transform_for_encdec
  import sm4_pkg::*;
(
  input  sm4_word_t x_i,
  output sm4_word_t t_o
);

  // One row per high nibble; the low nibble selects the byte from the left.
  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [127:0] row;
    row = SBOX_ROWS[a[7:4]] >> {~a[3:0], 3'b000};
    return row[7:0];
  endfunction

  sm4_word_t b;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign b[8*g +: 8] = sbox(x_i[8*g +: 8]);
  end

  assign t_o = b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);

endmodule

// File: rtl/sm4_round_ctrl.sv
// rtl/sm4_round_ctrl.sv - iterative SM4 block engine: 32 rounds through one shared T-transform
module sm4_round_ctrl
  import sm4_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_valid_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         decrypt_i,
  input  logic [127:0] data_i,
  output logic [4:0]   rk_idx_o,
  input  logic [31:0]  rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o,
  output logic         key_err_o
);

  localparam logic [4:0] LAST_CNT = 5'(SM4_ROUNDS - 1);

  sm4_ctrl_state_e state_q;
  sm4_word_t       x0_q, x1_q, x2_q, x3_q;
  logic [4:0]      cnt_q;
  logic            dec_q;
  sm4_word_t       t;

  transform_for_encdec u_t (
    .x_i (x1_q ^ x2_q ^ x3_q ^ rk_i),
    .t_o (t)
  );

  assign in_ready_o = (state_q == IDLE) && key_valid_i;
  // 31 - cnt is the bitwise complement for a 5-bit counter.
  assign rk_idx_o   = (state_q == ROUND) ? (dec_q ? ~cnt_q : cnt_q) : 5'd0;
  assign data_o     = out_valid_o ? {x3_q, x2_q, x1_q, x0_q} : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      key_err_o   <= 1'b0;
    end else begin
      key_err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            x0_q    <= data_i[127:96];
            x1_q    <= data_i[95:64];
            x2_q    <= data_i[63:32];
            x3_q    <= data_i[31:0];
            dec_q   <= decrypt_i;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          // A key schedule that goes away mid-block makes the block worthless.
          if (!key_valid_i) begin
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            cnt_q     <= '0;
            busy_o    <= 1'b0;
            key_err_o <= 1'b1;
            state_q   <= IDLE;
          end else begin
            x0_q  <= x1_q;
            x1_q  <= x2_q;
            x2_q  <= x3_q;
            x3_q  <= x0_q ^ t;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
              out_valid_o <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// tb/tb_sm4_round_ctrl.sv - self-checking bench for sm4_round_ctrl against a behavioural SM4 model
module tb_sm4_round_ctrl;

  localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] CT_1M = 128'h595298c7c6fd271f0402f804c33d3f66;
  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [127:0] SB [16] = '{
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic         clk = 1'b0;
  logic         rst, key_valid, in_valid, in_ready, decrypt;
  logic         out_valid, out_ready, busy, key_err;
  logic [127:0] data_in, data_out;
  logic [4:0]   rk_idx;
  logic [31:0]  rk;
  logic [31:0]  rk_tab [32];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  assign rk = rk_tab[rk_idx];

  sm4_round_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (key_valid),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .decrypt_i   (decrypt),
    .data_i      (data_in),
    .rk_idx_o    (rk_idx),
    .rk_i        (rk),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data_out),
    .busy_o      (busy),
    .key_err_o   (key_err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rol(input logic [31:0] w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] v;
      logic [127:0] row;
      v = a[8*i +: 8];
      row = SB[v[7:4]];
      b[8*i +: 8] = row[8*(15 - int'(v[3:0])) +: 8];
    end
    return b;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  function automatic void expand_key(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ FK[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'((4*i + j) * 7);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk_tab[i] = k[i+4];
    end
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din, input logic dec);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = din[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk_tab[dec ? 31 - i : i]);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk_i({tag, " out_valid"}, int'(out_valid), 0);
    chk_i({tag, " busy"}, int'(busy), 0);
    chk_i({tag, " key_err"}, int'(key_err), 0);
    chk_i({tag, " rk_idx"}, int'(rk_idx), 0);
    chk_b({tag, " data_o"}, data_out, 128'd0);
    chk_i({tag, " in_ready"}, int'(in_ready), int'(key_valid));
  endtask

  task automatic start_block(input logic [127:0] din, input logic dec, input logic ordy,
                             input string tag);
    int w = 0;
    @(negedge clk);
    data_in = din; decrypt = dec; in_valid = 1'b1; out_ready = ordy;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk_i({tag, " accepted"}, int'(w < 50), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic dec, output int cyc, output int idx_bad,
                             output int rdy_bad);
    cyc = 0; idx_bad = 0; rdy_bad = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (in_ready) rdy_bad++;
      if (out_valid) break;
      if (rk_idx !== 5'(dec ? 32 - cyc : cyc - 1)) idx_bad++;
    end
  endtask

  task automatic run_block(input logic [127:0] din, input logic dec, input string tag,
                           output logic [127:0] dout);
    int cyc, ib, rb;
    start_block(din, dec, 1'b1, tag);
    wait_result(dec, cyc, ib, rb);
    chk_i({tag, " latency"}, cyc, 33);
    chk_i({tag, " rk_idx order"}, ib, 0);
    chk_i({tag, " in_ready low"}, rb, 0);
    dout = data_out;
    @(negedge clk);
    chk_i({tag, " out_valid drop"}, int'(out_valid), 0);
    chk_i({tag, " in_ready back"}, int'(in_ready), 1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [127:0] got, held, x;
    int cyc, ib, rb, bad, pulses, seen;

    expand_key(MK);
    rst = 1'b1; key_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    decrypt = 1'b0; data_in = '0;

    chk_b("model encrypt", model(PT, 1'b0), CT);
    chk_b("model decrypt", model(CT, 1'b1), PT);

    vecs[0] = '{PT, 1'b0, CT};
    vecs[1] = '{CT, 1'b1, PT};
    for (int i = 2; i < 8; i++) begin
      vecs[i].din = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].dec = 1'(i % 2);
      vecs[i].exp = model(vecs[i].din, vecs[i].dec);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i].din, vecs[i].dec, $sformatf("vec%0d", i), got);
      chk_b($sformatf("vec%0d data", i), got, vecs[i].exp);
    end

    // back-pressure with a second block waiting
    start_block(PT, 1'b0, 1'b0, "bp");
    data_in = CT; decrypt = 1'b1; in_valid = 1'b1;
    wait_result(1'b0, cyc, ib, rb);
    chk_i("bp latency", cyc, 33);
    chk_i("bp rk_idx order", ib, 0);
    chk_b("bp data", data_out, CT);
    held = data_out;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_out !== held || !out_valid || in_ready) bad++;
    end
    chk_i("bp hold stable", bad, 0);
    chk_i("bp in_ready during DONE", int'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk_i("bp in_ready after handshake", int'(in_ready), 1);
    chk_i("bp out_valid after handshake", int'(out_valid), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(1'b1, cyc, ib, rb);
    chk_i("bp2 latency", cyc, 33);
    chk_i("bp2 rk_idx order", ib, 0);
    chk_b("bp2 data", data_out, PT);
    @(negedge clk);

    // key gating in IDLE
    key_valid = 1'b0; in_valid = 1'b1; data_in = PT; decrypt = 1'b0;
    #1 chk_i("gate in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk_i("gate busy", int'(busy), 0);
    in_valid = 1'b0; key_valid = 1'b1;

    // key loss at round 10 and at the final round
    for (int r = 0; r < 2; r++) begin
      int at;
      at = (r == 0) ? 10 : 31;
      start_block(PT, 1'b0, 1'b1, $sformatf("abort%0d", at));
      repeat (at + 1) @(negedge clk);
      chk_i($sformatf("abort%0d rk_idx", at), int'(rk_idx), at);
      key_valid = 1'b0;
      pulses = 0; seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (key_err) pulses++;
        if (out_valid) seen++;
        key_valid = 1'b1;
      end
      chk_i($sformatf("abort%0d key_err pulses", at), pulses, 1);
      chk_i($sformatf("abort%0d out_valid", at), seen, 0);
      chk_i($sformatf("abort%0d idle", at), int'(busy), 0);
    end

    // reset at round 5
    start_block(PT, 1'b0, 1'b1, "rst");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midop reset");
    rst = 1'b0;
    run_block(PT, 1'b0, "post-reset", got);
    chk_b("post-reset data", got, CT);

    // chained encryptions through the engine
    x = PT;
    for (int i = 0; i < 4; i++) begin
      run_block(x, 1'b0, $sformatf("chain%0d", i), got);
      chk_b($sformatf("chain%0d data", i), got, model(x, 1'b0));
      x = got;
    end

    x = PT;
    for (int i = 0; i < 1000000; i++) x = model(x, 1'b0);
    chk_b("model 1M chain", x, CT_1M);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sm4_round_ctrl.md
# sm4_round_ctrl

Iterative SM4 block engine controller: accepts one 128-bit block, sequences 32 rounds through a single instance of the T-transform (S-box layer plus linear diffusion L), and returns the result after the final reverse word order.
- Sits between the SM4 register interface (block in/out) and the round-key store produced by key expansion.
- Fetches one round key per cycle, in forward order for encryption and reverse order for decryption.

## Interface
- No parameters: the block is fixed at 128-bit blocks, 32-bit words and 32 rounds.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- key_valid_i  in  1  the round-key store holds a complete, stable key schedule.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  ready to accept a block.
- decrypt_i  in  1  operation select, sampled on accept: 0 = encrypt, 1 = decrypt.
- data_i  in  128  input block; X0 = data_i[127:96], X3 = data_i[31:0].
- rk_idx_o  out  5  round-key index requested this cycle.
- rk_i  in  32  round key rk[rk_idx_o], returned combinationally in the same cycle.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer ready.
- data_o  out  128  result block.
- busy_o  out  1  high in ROUND or DONE.
- key_err_o  out  1  one-cycle pulse when a block is aborted because the key became invalid.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready_o = key_valid_i.
  - On in_valid_i && in_ready_o: load X[0..3] from data_i, latch decrypt_i into dec_q, set cnt = 0, go to ROUND.
- ROUND, each cycle:
  - rk_idx_o = dec_q ? 31 - cnt : cnt.
  - Compute t = T(X1 ^ X2 ^ X3 ^ rk_i).
  - Shift: X0 <= X1, X1 <= X2, X2 <= X3, X3 <= X0 ^ t.
  - cnt increments.
  - On cnt == 31, the shift completes and the FSM goes to DONE.
- T(x) is the S-box on each byte, then L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
- DONE:
  - out_valid_o = 1.
  - data_o = {X3, X2, X1, X0}, i.e. the reverse transform R.
  - On out_ready_i, go to IDLE.
- Key loss:
  - key_valid_i low during ROUND: abort to IDLE, discard the block, pulse key_err_o for one cycle. No output is produced.
  - key_valid_i low during DONE has no effect; the result is already complete.
- cnt is 5 bits. Its wrap from 31 is never used, because the FSM leaves ROUND at 31.
- Reset values (also on rst_i asserted mid-operation):
  - state = IDLE.
  - X[0..3] = 0, cnt = 0, dec_q = 0.
  - in_ready_o = key_valid_i; all other outputs are 0, including rk_idx_o = 0 and data_o = 0.
- data_o is 0 outside DONE, so no intermediate state is exposed.

## Timing
- Accept edge is cycle 0.
- ROUND occupies cycles 1..32.
- out_valid_o rises in cycle 33, so latency is 33 cycles from the accept edge.
- No overlap between blocks:
  - in_ready_o is low from the cycle after accept until the cycle after the output handshake.
  - Maximum throughput is one block per 34 cycles.
- Handshakes:
  - in_valid_i may remain high across accept; only one block is taken.
  - data_o and out_valid_o are held stable until out_ready_i.
  - out_ready_i may already be high when out_valid_o rises; the handshake then completes in cycle 33.
- Critical path: register -> rk_idx_o -> key store read -> XOR3 -> S-box -> L -> XOR -> X3 register.
  - This is one round per cycle.
  - The key store read must be combinational.
- Simultaneous events:
  - rst_i wins over every handshake.
  - key_valid_i dropping in the same cycle as the final round (cnt == 31) still aborts.

## Structure
- Shared package sm4_pkg holds:
  - SM4_ROUNDS = 32.
  - state enum sm4_ctrl_state_e {IDLE, ROUND, DONE}.
  - typedef sm4_word_t (logic [31:0]).
  - typedef sm4_block_t (logic [127:0]).
- One sub-module: the existing combinational T-transform block (transform_for_encdec), instantiated once.
- Everything else (FSM, counter, X shift register, output mux) is flat in sm4_round_ctrl.

## Test plan
The bench models the key store with rk[0..31], expanded by a reference model from key 0123456789abcdeffedcba9876543210.
- Encrypt:
  - Stimulus: plaintext 0123456789abcdeffedcba9876543210, out_ready_i tied 1.
  - Required: data_o = 681edf34d206965e86b3e94f536e4246, out_valid_o in cycle 33; rk_idx_o steps 0..31.
- Decrypt:
  - Stimulus: input 681edf34d206965e86b3e94f536e4246.
  - Required: data_o = 0123456789abcdeffedcba9876543210; rk_idx_o steps 31..0.
- Back-pressure:
  - Stimulus: hold out_ready_i low for 10 cycles after out_valid_o, keep in_valid_i high with a second block.
  - Required: data_o stable; in_ready_o low until the cycle after the handshake; the second block then produces its correct result.
- Key gating and abort:
  - Stimulus: key_valid_i low in IDLE.
  - Required: in_ready_o = 0.
  - Stimulus: key_valid_i dropped at round 10.
  - Required: one key_err_o pulse, return to IDLE, no out_valid_o.
- Reset mid-op:
  - Stimulus: rst_i at round 5.
  - Required: next cycle all outputs at their reset values; a fresh encrypt afterwards yields 681edf34d206965e86b3e94f536e4246.
- Iteration:
  - Stimulus: 1,000,000 chained encryptions of the plaintext, each output fed back as the next input.
  - Required: 595298c7c6fd271f0402f804c33d3f66.
